// File: rtl/window_sequencer.sv
// window_sequencer: accepts a sample stream into a buffer, then walks the
// buffer in overlapping windows of SAMPLE_SIZE samples spaced HOP apart.
// Each window is captured with one proc_en strobe and presented downstream;
// HOP-1 further strobes after it advance the buffer read pointer to the next
// window start.
module window_sequencer #(
    parameter int SAMPLE_SIZE = 4096,
    parameter int HOP         = 1024,
    parameter int FILE_SIZE   = 4365900
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] wav_in,
    output logic        wr_en,
    output logic [31:0] wr_idx,
    output logic [15:0] wr_data,
    output logic        proc_en,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [31:0] win_start,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        SKIP    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [32:0] SS33 = 33'(SAMPLE_SIZE);
    localparam logic [32:0] HOP33 = 33'(HOP);
    localparam logic [32:0] FS33 = 33'(FILE_SIZE);
    localparam logic [31:0] HOP32 = 32'(HOP);
    localparam logic [31:0] SKIP_LOAD = 32'(HOP - 1);

    state_t      state_q;
    logic [31:0] wr_cnt_q;
    logic [31:0] next_start_q;
    logic [31:0] win_start_q;
    logic [31:0] skip_cnt_q;

    logic        accepting;
    logic        xfer;
    logic        avail;
    logic        last;
    logic        last_after_hop;
    logic [31:0] next_start_d;

    // Stream acceptance runs beside the FSM in every active state; reset
    // gates every output so nothing leaks out while rst_n is low.
    always_comb begin
        accepting = rst_n && (state_q != IDLE) && (state_q != DONE)
                    && ({1'b0, wr_cnt_q} < FS33);
        xfer      = in_valid && accepting;
        in_ready  = accepting;
        wr_en     = xfer;
        wr_idx    = xfer ? wr_cnt_q : 32'd0;
        wr_data   = xfer ? wav_in : 16'd0;
        proc_en   = rst_n && ((state_q == CAPTURE) || (state_q == SKIP));
        win_valid = rst_n && (state_q == PRESENT);
        busy      = rst_n && ((state_q == FILL) || (state_q == CAPTURE)
                              || (state_q == PRESENT) || (state_q == SKIP));
        done      = rst_n && (state_q == DONE);
        win_start = rst_n ? win_start_q : 32'd0;
    end

    // Window bookkeeping in 33 bits so offsets near the top of the range
    // never wrap. avail uses the registered count, so a sample written this
    // cycle cannot release a capture in the same cycle.
    always_comb begin
        next_start_d   = next_start_q + HOP32;
        avail          = {1'b0, wr_cnt_q} >= ({1'b0, next_start_q} + SS33);
        last           = ({1'b0, next_start_q} + SS33) > FS33;
        // When the window after this one cannot exist, skipping would only
        // move the buffer pointer past the final window for nothing.
        last_after_hop = ({1'b0, next_start_q} + HOP33 + SS33) > FS33;
    end

    // Sequencer FSM together with the sample counter and window offsets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_cnt_q     <= 32'd0;
            next_start_q <= 32'd0;
            win_start_q  <= 32'd0;
            skip_cnt_q   <= 32'd0;
        end else begin
            if (xfer) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= FILL;
                        wr_cnt_q     <= 32'd0;
                        next_start_q <= 32'd0;
                        win_start_q  <= 32'd0;
                    end
                end
                FILL: begin
                    if (last) begin
                        state_q <= DONE;
                    end else if (avail) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    win_start_q <= next_start_q;
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    if (win_ready) begin
                        next_start_q <= next_start_d;
                        if ((HOP > 1) && !last_after_hop) begin
                            skip_cnt_q <= SKIP_LOAD;
                            state_q    <= SKIP;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                SKIP: begin
                    skip_cnt_q <= skip_cnt_q - 32'd1;
                    if (skip_cnt_q <= 32'd1) begin
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_sequencer.sv
// Bench for window_sequencer: two instances (HOP=2 and HOP=4) driven with
// randomized sample and window-ready traffic, checked against expected
// window offsets and strobe counts derived from the window arithmetic.
module tb_window_sequencer;

    localparam int SS = 4;
    localparam int FS = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]       start_v;
    logic [1:0]       in_valid_v;
    logic [1:0]       in_ready_v;
    logic [1:0][15:0] wav_in_v;
    logic [1:0]       wr_en_v;
    logic [1:0][31:0] wr_idx_v;
    logic [1:0][15:0] wr_data_v;
    logic [1:0]       proc_en_v;
    logic [1:0]       win_valid_v;
    logic [1:0]       win_ready_v;
    logic [1:0][31:0] win_start_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        window_sequencer #(
            .SAMPLE_SIZE(SS),
            .HOP        ((gi == 0) ? 2 : 4),
            .FILE_SIZE  (FS)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_v[gi]),
            .in_valid (in_valid_v[gi]),
            .in_ready (in_ready_v[gi]),
            .wav_in   (wav_in_v[gi]),
            .wr_en    (wr_en_v[gi]),
            .wr_idx   (wr_idx_v[gi]),
            .wr_data  (wr_data_v[gi]),
            .proc_en  (proc_en_v[gi]),
            .win_valid(win_valid_v[gi]),
            .win_ready(win_ready_v[gi]),
            .win_start(win_start_v[gi]),
            .busy     (busy_v[gi]),
            .done     (done_v[gi])
        );
    end

    function automatic int hop_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    logic [15:0] mem [FS];
    int  vmode [2];   // 0 always valid, 1 every 3rd cycle, 2 random
    int  rmode [2];   // 0 always ready, 1 random, 2 stall 5 cycles at offset 4, 3 never
    logic tmo_req;

    // ---------------- stimulus: sample stream and downstream ready ----------
    initial begin
        int  ptr [2];
        int  hold [2];
        logic acc [2];
        logic rstart [2];
        logic rs;
        int  cyc;
        logic v;
        in_valid_v  = '0;
        wav_in_v    = '0;
        win_ready_v = '1;
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0;
            hold[d] = 0;
        end
        forever begin
            @(negedge clk);
            rs = rst_n;
            for (int d = 0; d < 2; d++) begin
                acc[d]    = in_valid_v[d] && in_ready_v[d];
                rstart[d] = start_v[d] && !busy_v[d];
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rs || rstart[d]) begin
                    ptr[d] = 0;
                    hold[d] = 0;
                end else if (acc[d]) begin
                    ptr[d]++;
                end
                case (vmode[d])
                    0:       v = 1'b1;
                    1:       v = (cyc % 3 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                in_valid_v[d] = v && (ptr[d] < FS);
                wav_in_v[d]   = (ptr[d] < FS) ? mem[ptr[d]] : 16'($urandom);
                case (rmode[d])
                    0: win_ready_v[d] = 1'b1;
                    1: win_ready_v[d] = 1'($urandom_range(0, 1));
                    2: begin
                        if (win_valid_v[d] && win_start_v[d] == 32'd4 && hold[d] < 5) begin
                            win_ready_v[d] = 1'b0;
                            hold[d]++;
                        end else begin
                            win_ready_v[d] = 1'b1;
                        end
                    end
                    default: win_ready_v[d] = 1'b0;
                endcase
            end
        end
    end

    // ---------------- scoreboard / monitor ---------------------------------
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    int  exp_win [2][$];
    logic active [2];
    logic fresh [2];
    logic after_rst [2];
    int  mcnt [2];
    int  pulses [2];
    int  nwin [2];
    int  cycles [2];
    logic tmo_seen = 1'b0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            active[d] = 1'b0;
            after_rst[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (tmo_req && !tmo_seen) begin
            chk("main_wait_timeout", 64'(tmo_req), 64'd0);
            tmo_seen = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("reset_flags", 64'({in_ready_v[d], wr_en_v[d], proc_en_v[d],
                                        win_valid_v[d], busy_v[d], done_v[d]}), 64'd0);
                chk("reset_wr_port", 64'({wr_idx_v[d], wr_data_v[d]}), 64'd0);
                chk("reset_win_start", 64'(win_start_v[d]), 64'd0);
                active[d] = 1'b0;
                exp_win[d].delete();
                mcnt[d] = 0;
                pulses[d] = 0;
                after_rst[d] = 1'b1;
            end else begin
                if (after_rst[d]) begin
                    chk("post_reset_idle", 64'({busy_v[d], done_v[d], win_start_v[d]}), 64'd0);
                    after_rst[d] = 1'b0;
                end
                if (!active[d]) begin
                    chk("idle_quiet", 64'({in_ready_v[d], wr_en_v[d], proc_en_v[d],
                                           win_valid_v[d]}), 64'd0);
                    if (start_v[d]) begin
                        active[d] = 1'b1;
                        fresh[d]  = 1'b1;
                        mcnt[d]   = 0;
                        pulses[d] = 0;
                        cycles[d] = 0;
                        nwin[d]   = 0;
                        exp_win[d].delete();
                        for (int s = 0; s + SS <= FS; s += hop_of(d)) begin
                            exp_win[d].push_back(s);
                            nwin[d]++;
                        end
                    end
                end else begin
                    cycles[d]++;
                    if (done_v[d]) begin
                        chk("done_windows_left", 64'(exp_win[d].size()), 64'd0);
                        chk("done_proc_pulses", 64'(pulses[d]),
                            64'((nwin[d] - 1) * hop_of(d) + 1));
                        chk("done_ready_busy", 64'({in_ready_v[d], busy_v[d], wr_en_v[d]}), 64'd0);
                        $display("dut%0d stream done: windows=%0d pulses=%0d samples=%0d",
                                 d, nwin[d], pulses[d], mcnt[d]);
                        active[d] = 1'b0;
                    end else begin
                        if (!fresh[d]) begin
                            chk("busy", 64'(busy_v[d]), 64'd1);
                        end
                        fresh[d] = 1'b0;
                        if (proc_en_v[d]) begin
                            chk("proc_with_valid", 64'(win_valid_v[d]), 64'd0);
                            if (pulses[d] % hop_of(d) == 0) begin
                                chk("capture_data_ready", 64'(mcnt[d] >= pulses[d] + SS), 64'd1);
                            end
                            pulses[d]++;
                        end
                        if (win_valid_v[d]) begin
                            if (exp_win[d].size() == 0) begin
                                chk("window_extra", 64'(exp_win[d].size()), 64'd1);
                            end else begin
                                chk("win_start", 64'(win_start_v[d]), 64'(exp_win[d][0]));
                                chk("win_read_ptr", 64'(win_start_v[d]), 64'(pulses[d] - 1));
                                if (win_ready_v[d]) begin
                                    $display("dut%0d window start=%0d", d, win_start_v[d]);
                                    void'(exp_win[d].pop_front());
                                end
                            end
                        end
                        if (wr_en_v[d]) begin
                            chk("wr_idx", 64'(wr_idx_v[d]), 64'(mcnt[d]));
                            if (mcnt[d] < FS) begin
                                chk("wr_data", 64'(wr_data_v[d]), 64'(mem[mcnt[d]]));
                            end else begin
                                chk("wr_past_end", 64'(mcnt[d]), 64'(FS - 1));
                            end
                            mcnt[d]++;
                        end
                        if (cycles[d] > 600) begin
                            chk("stream_timeout", 64'(cycles[d]), 64'd0);
                            active[d] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- scenario sequencing ----------------------------------
    task automatic pulse_start();
        start_v = 2'b11;
        @(posedge clk);
        #1;
        start_v = 2'b00;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            if (done_v == 2'b11) break;
        end
        if (done_v != 2'b11) tmo_req = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_modes(input int v0, input int v1, input int r0, input int r1);
        vmode[0] = v0;
        vmode[1] = v1;
        rmode[0] = r0;
        rmode[1] = r1;
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = 2'b00;
        tmo_req = 1'b0;
        set_modes(0, 0, 0, 0);
        for (int i = 0; i < FS; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // back-to-back samples, always ready
        set_modes(0, 0, 0, 0);
        pulse_start();
        wait_done();

        // sparse samples, random ready (restart from DONE)
        set_modes(1, 1, 1, 1);
        pulse_start();
        wait_done();

        // stall at offset 4, random samples, start pulsed mid-stream
        set_modes(2, 2, 2, 1);
        pulse_start();
        repeat (8) @(posedge clk);
        #1;
        pulse_start();
        wait_done();

        // reset while a window is being presented, then restart
        set_modes(0, 2, 3, 1);
        pulse_start();
        begin
            int n;
            for (n = 0; n < 200; n++) begin
                @(negedge clk);
                if (win_valid_v[0]) break;
            end
            if (!win_valid_v[0]) tmo_req = 1'b1;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_modes(2, 0, 0, 1);
        pulse_start();
        wait_done();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/window_sequencer.md
WINDOW_SEQUENCER -- requirements
Module: window_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_SIZE, default 4096, meaning samples per window.
REQ-002 SHALL have parameter HOP, default 1024, range 1..SAMPLE_SIZE, meaning sample offset between consecutive windows.
REQ-003 SHALL have parameter FILE_SIZE, default 4365900, meaning total samples in one stream.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that begins a stream; ignored unless in IDLE.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and wav_in (input, 16), the sample-stream handshake.
REQ-008 SHALL have ports wr_en (output, 1), wr_idx (output, 32) and wr_data (output, 16), the sample-buffer write port (enable/idx/wav_input).
REQ-009 SHALL have port proc_en, output, 1, the buffer advance/capture strobe (enable_process).
REQ-010 SHALL have ports win_valid (output, 1) and win_ready (input, 1), the downstream window handshake.
REQ-011 SHALL have port win_start, output, 32, the sample offset of the presented window.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1), status flags.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, CAPTURE, PRESENT, SKIP and DONE.
REQ-014 SHALL keep wr_cnt (32b), the count of accepted samples, cleared on start.
REQ-015 SHALL drive in_ready=1 whenever state is not IDLE or DONE and wr_cnt<FILE_SIZE.
- Transfer occurs when in_valid && in_ready.
REQ-016 SHALL, on each transfer, in the same cycle drive wr_en=1, wr_idx=wr_cnt and wr_data=wav_in (combinational pass-through), then increment wr_cnt.
- Sample acceptance runs in every state other than IDLE/DONE, concurrently with the FSM.
REQ-017 SHALL keep next_start (32b), the offset of the next window to capture, cleared on start.
REQ-018 SHALL define avail = (wr_cnt >= next_start+SAMPLE_SIZE) using the registered wr_cnt, so samples written in the current cycle are never counted.
REQ-019 SHALL define last = (next_start+SAMPLE_SIZE > FILE_SIZE), evaluated with 33-bit arithmetic (no wrap).
REQ-020 SHALL transition IDLE->FILL on start, clearing wr_cnt, next_start and win_start.
REQ-021 SHALL in FILL go to DONE if last, else to CAPTURE if avail, else stay in FILL.
REQ-022 SHALL in CAPTURE pulse proc_en=1 for exactly one cycle, load win_start<=next_start, and go to PRESENT.
REQ-023 SHALL in PRESENT hold win_valid=1 and win_start stable until win_ready=1.
- On that handshake cycle: next_start<=next_start+HOP; go to SKIP if HOP>1, else to FILL.
- win_valid first rises the cycle after the proc_en pulse (the buffer output is registered).
REQ-024 SHALL in SKIP issue HOP-1 consecutive single-cycle proc_en pulses (no win_valid) via a skip counter, then go to FILL.
- Keeps the buffer read pointer equal to next_start.
REQ-025 SHALL in DONE hold done=1 and in_ready=0 until start, which behaves as in IDLE.
REQ-026 SHALL drive busy=1 in FILL, CAPTURE, PRESENT and SKIP, and busy=0 otherwise.
REQ-027 SHALL drive proc_en only in CAPTURE and SKIP, and never assert it while win_valid=1.
REQ-028 SHALL ignore start when not in IDLE/DONE; a stream cannot be restarted mid-operation except by reset.
REQ-029 SHALL limit total proc_en pulses per stream to (windows-1)*HOP+1.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, force state=IDLE and clear wr_cnt, next_start, win_start and the skip counter.
REQ-031 SHALL hold in_ready, wr_en, proc_en, win_valid, busy and done at 0 during reset; wr_idx, wr_data and win_start read 0.
REQ-032 SHALL, on reset mid-stream, abandon that stream immediately with no further wr_en or proc_en pulses.

Verification (SAMPLE_SIZE=4, HOP=2, FILE_SIZE=10)
REQ-033 SHALL be tested with start and 10 back-to-back samples, win_ready=1 -> wr_idx 0..9; windows at win_start 0,2,4,6; 7 proc_en pulses total; then done=1 and in_ready=0.
REQ-034 SHALL be tested with samples arriving every 3rd cycle -> first proc_en only in the cycle after wr_cnt reaches 4; no capture precedes its last sample write.
REQ-035 SHALL be tested with win_ready held 0 for 5 cycles at window 2 -> win_valid and win_start=4 held stable; no proc_en; samples still accepted.
REQ-036 SHALL be tested with rst_n=0 asserted while in PRESENT -> next cycle all outputs 0, state IDLE; a new start restarts with wr_idx=0.
REQ-037 SHALL be tested with start pulsed while busy -> no effect on counters or outputs.
REQ-038 SHALL be tested with HOP=4 (no overlap) -> windows at 0 and 4, SKIP issues 3 pulses, done after 2 windows.
